// File: rtl/oled_frame_buffer.sv
// SSD1306-ordered monochrome frame buffer: pixel RMW writer, bulk clear,
// and an independent registered display read port.
module oled_frame_buffer #(
    parameter int WIDTH_PX = 128,
    parameter int HEIGHT_PX = 64,
    localparam int XW = $clog2(WIDTH_PX),
    localparam int YW = $clog2(HEIGHT_PX),
    localparam int DEPTH = WIDTH_PX * HEIGHT_PX / 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_arst,
    input  logic          i_pix_valid,
    output logic          o_pix_ready,
    input  logic [XW-1:0] i_pix_x,
    input  logic [YW-1:0] i_pix_y,
    input  logic          i_pix_on,
    input  logic          i_clear,
    input  logic          i_clear_val,
    input  logic [AW-1:0] i_rd_addr,
    output logic [7:0]    o_rd_data,
    output logic          o_busy,
    output logic          o_dirty,
    input  logic          i_dirty_ack
);

    typedef enum logic [1:0] {
        IDLE,
        RMW_RD,
        RMW_WR,
        CLEAR
    } state_t;

    localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

    logic [7:0]    mem [DEPTH];

    state_t        state_q;
    state_t        state_d;
    logic [XW-1:0] lat_x;
    logic [YW-1:0] lat_y;
    logic          lat_on;
    logic [7:0]    fill_q;
    logic [AW:0]   cnt_q;
    logic [7:0]    rmw_q;
    logic          dirty_q;
    logic [7:0]    rd_q;

    logic          in_range;
    logic [AW-1:0] pix_addr;
    logic [7:0]    mask;
    logic [7:0]    wr_byte;
    logic          clr_last;

    logic          pix_ready;
    logic          accept;
    logic          clr_start;
    logic          we;
    logic [AW-1:0] wa;
    logic [7:0]    wd;
    logic          dirty_set;

    always_comb begin
        in_range = (int'(lat_x) < WIDTH_PX) && (int'(lat_y) < HEIGHT_PX);
        pix_addr = '0;
        if (in_range)
            pix_addr = AW'((int'(lat_y) >> 3) * WIDTH_PX + int'(lat_x));
        mask     = 8'(1) << lat_y[2:0];
        wr_byte  = lat_on ? (rmw_q | mask) : (rmw_q & ~mask);
        clr_last = (cnt_q == LAST);
    end

    // state register
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_clear)
                    state_d = CLEAR;
                else if (i_pix_valid)
                    state_d = RMW_RD;
            end
            RMW_RD: state_d = RMW_WR;
            RMW_WR: state_d = IDLE;
            CLEAR: begin
                if (clr_last)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // outputs and port-A controls; ready is masked during reset
    always_comb begin
        pix_ready = 1'b0;
        clr_start = 1'b0;
        we        = 1'b0;
        wa        = '0;
        wd        = '0;
        dirty_set = 1'b0;
        o_busy    = 1'b1;
        case (state_q)
            IDLE: begin
                o_busy    = 1'b0;
                pix_ready = i_arst & ~i_clear;
                clr_start = i_clear;
            end
            RMW_RD: ;
            RMW_WR: begin
                we        = in_range;
                wa        = pix_addr;
                wd        = wr_byte;
                dirty_set = in_range;
            end
            CLEAR: begin
                we        = 1'b1;
                wa        = cnt_q[AW-1:0];
                wd        = fill_q;
                dirty_set = clr_last;
            end
            default: o_busy = 1'b0;
        endcase
        accept = pix_ready & i_pix_valid;
    end

    assign o_pix_ready = pix_ready;
    assign o_dirty     = dirty_q;
    assign o_rd_data   = rd_q;

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            lat_x   <= '0;
            lat_y   <= '0;
            lat_on  <= 1'b0;
            fill_q  <= '0;
            cnt_q   <= '0;
            rmw_q   <= '0;
            dirty_q <= 1'b0;
            rd_q    <= '0;
        end else begin
            rd_q <= mem[i_rd_addr];
            if (accept) begin
                lat_x  <= i_pix_x;
                lat_y  <= i_pix_y;
                lat_on <= i_pix_on;
            end
            if (clr_start) begin
                fill_q <= {8{i_clear_val}};
                cnt_q  <= '0;
            end else if (state_q == CLEAR) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == RMW_RD)
                rmw_q <= mem[pix_addr];
            if (dirty_set)
                dirty_q <= 1'b1;
            else if (i_dirty_ack)
                dirty_q <= 1'b0;
        end
    end

    // storage itself is never reset
    always_ff @(posedge i_clk) begin
        if (we)
            mem[wa] <= wd;
    end

endmodule

// File: tb/tb_oled_frame_buffer.sv
// Scoreboard bench for oled_frame_buffer: read expectations are queued,
// a monitor pops them when registered read data is presented.
module tb_oled_frame_buffer;

    logic       i_clk = 1'b0;
    logic       i_arst;
    logic       i_pix_valid;
    logic       o_pix_ready;
    logic [6:0] i_pix_x;
    logic [5:0] i_pix_y;
    logic       i_pix_on;
    logic       i_clear;
    logic       i_clear_val;
    logic [9:0] i_rd_addr;
    logic [7:0] o_rd_data;
    logic       o_busy;
    logic       o_dirty;
    logic       i_dirty_ack;

    oled_frame_buffer dut (
        .i_clk       (i_clk),
        .i_arst      (i_arst),
        .i_pix_valid (i_pix_valid),
        .o_pix_ready (o_pix_ready),
        .i_pix_x     (i_pix_x),
        .i_pix_y     (i_pix_y),
        .i_pix_on    (i_pix_on),
        .i_clear     (i_clear),
        .i_clear_val (i_clear_val),
        .i_rd_addr   (i_rd_addr),
        .o_rd_data   (o_rd_data),
        .o_busy      (o_busy),
        .o_dirty     (o_dirty),
        .i_dirty_ack (i_dirty_ack)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } item_t;

    item_t q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    logic  rd_en = 1'b0;
    logic  rd_pend = 1'b0;
    int    cyc;

    always @(posedge i_clk) rd_pend <= rd_en;

    always @(negedge i_clk) begin
        item_t it;
        if (rd_pend) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL rd_noexp: got %02h, required none queued", o_rd_data);
            end else begin
                it = q.pop_front();
                if (o_rd_data !== it.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %02h, required %02h", it.name, o_rd_data, it.exp);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic rd(input int a, input logic [7:0] exp, input string nm);
        item_t it;
        @(negedge i_clk);
        i_rd_addr = 10'(a);
        rd_en = 1'b1;
        it.name = nm;
        it.exp = exp;
        q.push_back(it);
        @(negedge i_clk);
        rd_en = 1'b0;
    endtask

    task automatic do_clear(input logic v, input bit coll, output int c);
        item_t it;
        @(negedge i_clk);
        i_clear = 1'b1;
        i_clear_val = v;
        @(negedge i_clk);
        i_clear = 1'b0;
        i_clear_val = ~v;
        if (coll) begin
            i_rd_addr = 10'd0;
            rd_en = 1'b1;
            it.name = "coll_old";
            it.exp = 8'h00;
            q.push_back(it);
        end
        c = 0;
        while (o_busy && c < 3000) begin
            c++;
            @(negedge i_clk);
            if (coll && c == 1) begin
                it.name = "coll_new";
                it.exp = 8'hFF;
                q.push_back(it);
            end
            if (coll && c == 2) rd_en = 1'b0;
        end
    endtask

    task automatic pix(input int x, input int y, input logic on, input bit ack_wr);
        int w;
        @(negedge i_clk);
        i_pix_valid = 1'b1;
        i_pix_x = 7'(x);
        i_pix_y = 6'(y);
        i_pix_on = on;
        chk("rdy_acc", 32'(o_pix_ready), 1);
        @(negedge i_clk);
        i_pix_valid = 1'b0;
        w = 1;
        while (!o_pix_ready && w < 10) begin
            if (ack_wr && w == 2) i_dirty_ack = 1'b1;
            @(negedge i_clk);
            i_dirty_ack = 1'b0;
            w++;
        end
        chk("rdy_gap", w, 3);
    endtask

    task automatic ack();
        @(negedge i_clk);
        i_dirty_ack = 1'b1;
        @(negedge i_clk);
        i_dirty_ack = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    initial begin
        i_arst = 1'b0;
        i_pix_valid = 1'b0;
        i_pix_x = '0;
        i_pix_y = '0;
        i_pix_on = 1'b0;
        i_clear = 1'b0;
        i_clear_val = 1'b0;
        i_rd_addr = '0;
        i_dirty_ack = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_dirty", 32'(o_dirty), 0);
        chk("rst_ready", 32'(o_pix_ready), 0);
        chk("rst_rd", 32'(o_rd_data), 0);
        i_arst = 1'b1;
        #1;
        chk("rdy_rel", 32'(o_pix_ready), 1);

        do_clear(1'b0, 1'b0, cyc);
        chk("clr0_cyc", cyc, 1024);
        chk("clr0_dirty", 32'(o_dirty), 1);
        for (int a = 0; a < 1024; a++) rd(a, 8'h00, "clr0");
        ack();
        chk("ack0_dirty", 32'(o_dirty), 0);

        pix(5, 10, 1'b1, 1'b0);
        pix(5, 13, 1'b1, 1'b0);
        rd(133, 8'h24, "pix133");
        rd(132, 8'h00, "pix132");
        chk("pix_dirty", 32'(o_dirty), 1);

        do_clear(1'b1, 1'b1, cyc);
        chk("clr1_cyc", cyc, 1024);
        pix(127, 63, 1'b0, 1'b0);
        rd(1023, 8'h7F, "pix1023");
        rd(1022, 8'hFF, "pix1022");

        @(negedge i_clk);
        i_clear = 1'b1;
        i_clear_val = 1'b0;
        i_pix_valid = 1'b1;
        i_pix_x = 7'd0;
        i_pix_y = 6'd0;
        i_pix_on = 1'b1;
        #1;
        chk("both_rdy", 32'(o_pix_ready), 0);
        @(negedge i_clk);
        i_clear = 1'b0;
        chk("both_busy", 32'(o_busy), 1);
        cyc = 0;
        while (o_busy && cyc < 3000) begin
            cyc++;
            @(negedge i_clk);
        end
        chk("both_cyc", cyc, 1024);
        chk("both_rdy2", 32'(o_pix_ready), 1);
        @(negedge i_clk);
        i_pix_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        rd(0, 8'h01, "both_b0");
        rd(1, 8'h00, "both_b1");

        @(negedge i_clk);
        i_clear = 1'b1;
        i_clear_val = 1'b1;
        @(negedge i_clk);
        i_clear = 1'b0;
        repeat (500) @(negedge i_clk);
        i_arst = 1'b0;
        #1;
        chk("abort_busy", 32'(o_busy), 0);
        chk("abort_dirty", 32'(o_dirty), 0);
        chk("abort_rdy", 32'(o_pix_ready), 0);
        @(negedge i_clk);
        i_arst = 1'b1;
        #1;
        chk("abort_rel", 32'(o_pix_ready), 1);
        rd(100, 8'hFF, "abort100");
        rd(600, 8'h00, "abort600");
        pix(88, 32, 1'b1, 1'b0);
        chk("px_dirty", 32'(o_dirty), 1);
        rd(600, 8'h01, "px600");
        pix(4, 4, 1'b1, 1'b1);
        chk("ackset_dirty", 32'(o_dirty), 1);
        ack();
        chk("ack_dirty", 32'(o_dirty), 0);

        repeat (3) @(negedge i_clk);
        chk("q_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/oled_frame_buffer.md
OLED_FRAME_BUFFER -- requirements
Module: oled_frame_buffer

Interface
REQ-001 Parameter WIDTH_PX, default 128, meaning display width in pixels (SSD1306 columns).
REQ-002 Parameter HEIGHT_PX, default 64, meaning display height in pixels, a multiple of 8.
REQ-003 Derived constants: XW = clog2(WIDTH_PX), YW = clog2(HEIGHT_PX), DEPTH = WIDTH_PX*HEIGHT_PX/8 bytes, AW = clog2(DEPTH); defaults are 7, 6, 1024 and 10.
REQ-004 i_clk  input  1  single clock; all logic is on the rising edge.
REQ-005 i_arst  input  1  reset, asynchronous and active-low (0 = reset).
REQ-006 i_pix_valid  input  1  pixel write request.
REQ-007 o_pix_ready  output  1  the block accepts a pixel this cycle.
REQ-008 i_pix_x  input  XW  pixel column.
REQ-009 i_pix_y  input  YW  pixel row.
REQ-010 i_pix_on  input  1  pixel value (1 = lit).
REQ-011 i_clear  input  1  level request to fill the whole buffer.
REQ-012 i_clear_val  input  1  fill value: 0 gives 8'h00 per byte, 1 gives 8'hFF per byte.
REQ-013 i_rd_addr  input  AW  display-side byte address, driven by the downstream OLED config stage.
REQ-014 o_rd_data  output  8  display-side byte, registered.
REQ-015 o_busy  output  1  a clear or a pixel read-modify-write is in progress.
REQ-016 o_dirty  output  1  buffer changed since the last acknowledge.
REQ-017 i_dirty_ack  input  1  single-cycle pulse that clears o_dirty.

Function
REQ-018 Storage SHALL be DEPTH x 8 bits in SSD1306 horizontal-addressing order: byte address = (y>>3)*WIDTH_PX + x, bit index = y[2:0], with bit 0 as the top row of the page.
REQ-019 The storage SHALL have two ports:
- Port A, read/write, is owned by the state machine.
- Port B, read-only, serves i_rd_addr.
REQ-020 o_rd_data SHALL equal the byte at the i_rd_addr value sampled on the previous edge (1-cycle latency), independent of the state machine.
REQ-021 When port B reads an address that port A writes on the same edge, o_rd_data SHALL return the old byte.
REQ-022 State machine states SHALL be IDLE, RMW_RD, RMW_WR and CLEAR.
REQ-023 o_pix_ready SHALL be 1 only in IDLE with i_clear = 0.
REQ-024 o_busy SHALL be 1 in every state except IDLE.
REQ-025 IDLE transitions:
- i_clear = 1 goes to CLEAR, loads the fill byte and sets the clear counter to 0.
- Otherwise, i_pix_valid = 1 latches x, y and on, and goes to RMW_RD.
- Otherwise, stay in IDLE.
REQ-026 On a simultaneous i_clear and i_pix_valid in IDLE, the clear SHALL win and the pixel SHALL NOT be accepted (ready = 0).
REQ-027 RMW_RD SHALL issue a port A read of the latched byte address, then go to RMW_WR.
REQ-028 RMW_WR SHALL write the read byte with the latched bit set or cleared per the latched on value, then return to IDLE.
REQ-029 Pixel throughput SHALL be one pixel per 3 cycles, with a new acceptance possible on the cycle after RMW_WR.
REQ-030 A latched pixel with x >= WIDTH_PX or y >= HEIGHT_PX SHALL pass through RMW_RD and RMW_WR with no write and no dirty set.
REQ-031 CLEAR SHALL write the fill byte to port A at address = counter, incrementing once per cycle.
REQ-032 After writing address DEPTH-1, CLEAR SHALL return to IDLE; a clear takes exactly DEPTH cycles in CLEAR.
REQ-033 i_clear, i_pix_valid and i_clear_val changes SHALL be ignored outside IDLE; the fill byte is fixed at clear entry.
REQ-034 o_dirty SHALL set on the RMW_WR edge of an in-range pixel write and on the final CLEAR write.
REQ-035 o_dirty SHALL clear on i_dirty_ack; when a set and an acknowledge occur on the same edge, set SHALL win.
REQ-036 The clear counter SHALL be AW+1 bits wide so the termination compare has no wrap-around.

Reset
REQ-037 While i_arst = 0, outputs SHALL be: state IDLE, o_pix_ready 0, o_busy 0, o_dirty 0, o_rd_data 8'h00, clear counter 0, latched pixel registers 0.
REQ-038 Reset SHALL NOT modify storage contents; power-up contents are undefined until the first clear.
REQ-039 Reset asserted mid-RMW or mid-CLEAR SHALL abort immediately, with no further writes after reset assertion.
REQ-040 o_pix_ready SHALL be 1 on the first edge after release, provided i_clear = 0.

Verification
REQ-041 Reset release, clear with i_clear_val = 0, wait for o_busy to fall -> exactly 1024 cycles in CLEAR; every address reads 8'h00 via port B one cycle after i_rd_addr; o_dirty = 1.
REQ-042 After a zero clear, pixels (5,10,1) then (5,13,1) -> byte 133 reads 8'h24; o_pix_ready returns 1 three cycles after each accept.
REQ-043 After a 8'hFF clear, pixel (127,63,0) -> byte 1023 reads 8'h7F; byte 1022 stays 8'hFF.
REQ-044 i_clear and i_pix_valid high together in IDLE -> CLEAR entered and pixel not accepted; the pixel is accepted after the clear completes.
REQ-045 Abort and acknowledge, in sequence:
- Assert i_arst = 0 at counter 500 of a clear -> o_busy = 0 and o_dirty = 0 immediately.
- Release reset, then write one pixel -> o_dirty = 1.
- Pulse i_dirty_ack on the same edge as a further pixel's RMW_WR -> o_dirty stays 1.
- Pulse i_dirty_ack alone -> o_dirty = 0.
